// File: rtl/vec_accum_mem_if.sv
// Request/response bus of vec_accum_mem: one multi-lane request per cycle in,
// registered READ data out one cycle after acceptance.
interface vec_accum_mem_if #(
    parameter int LANES = 4,
    parameter int DW    = 32,
    parameter int AW    = 10
);
    logic                req_valid;
    logic                req_ready;
    logic [1:0]          req_op;
    logic [LANES-1:0]    req_lane_en;
    logic [LANES*AW-1:0] req_addr;
    logic [LANES*DW-1:0] req_wdata;
    logic                rsp_valid;
    logic [LANES*DW-1:0] rsp_rdata;

    modport master (
        output req_valid, req_op, req_lane_en, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_op, req_lane_en, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/vec_accum_mem.sv
// Multi-lane vector scratch/accumulation memory with READ/WRITE/ACC and a clear sequencer.
// Optional feature macro ACC_SAT_EN: saturating ACC results plus the acc_sat pulse.
module vec_accum_mem #(
    parameter int LANES = 4,
    parameter int DW    = 32,
    parameter int DEPTH = 1024
) (
    input  logic           clk,
    input  logic           rst_n,
    vec_accum_mem_if.slave bus,
    input  logic           clr_start,
    output logic           busy,
    output logic           acc_sat
);
    localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int AW1 = AW + 1;
`ifdef ACC_SAT_EN
    localparam int EW  = DW + $clog2(LANES + 1);
`else
    localparam int EW  = DW;
`endif

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_ACC   = 2'b10;

    typedef enum logic {ST_IDLE = 1'b0, ST_CLEAR = 1'b1} state_t;

    function automatic logic in_range(input logic [AW-1:0] a);
        return (32'(a) < 32'(DEPTH));
    endfunction

    function automatic logic [EW-1:0] sext(input logic [DW-1:0] v);
        return EW'($signed(v));
    endfunction

`ifdef ACC_SAT_EN
    function automatic logic clips(input logic [EW-1:0] v);
        return !((&v[EW-1:DW-1]) || !(|v[EW-1:DW-1]));
    endfunction

    function automatic logic [DW-1:0] sat_val(input logic [EW-1:0] v);
        logic [DW-1:0] r;
        if (clips(v)) begin
            r = v[EW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
        end else begin
            r = v[DW-1:0];
        end
        return r;
    endfunction
`endif

    state_t              state_r;
    logic [AW-1:0]       clr_base_r;
    logic                busy_r;
    logic                s1_valid_r;
    logic [1:0]          s1_op_r;
    logic [LANES-1:0]    s1_en_r;
    logic [LANES*AW-1:0] s1_addr_r;
    logic [LANES*DW-1:0] s1_wdata_r;
    logic                rsp_valid_r;
    logic [LANES*DW-1:0] rsp_rdata_r;
    logic [DW-1:0]       mem_r [DEPTH];

    logic                ready_s;
    logic                accept_s;
    logic [LANES-1:0]    lane_en_s;
    logic [LANES-1:0]    lane_win_s;
    logic [LANES-1:0]    lane_wr_s;
    logic [AW-1:0]       lane_addr_s [LANES];
    logic [DW-1:0]       lane_old_s  [LANES];
    logic [DW-1:0]       lane_wval_s [LANES];
    logic [LANES*DW-1:0] rd_data_s;
    logic                clr_last_s;
    logic [LANES-1:0]    clr_hit_s;
    logic [AW-1:0]       clr_idx_s   [LANES];
`ifdef ACC_SAT_EN
    logic [LANES-1:0]    lane_clip_s;
    logic                acc_sat_r;
`endif

    assign ready_s       = (state_r == ST_IDLE) && !clr_start;
    assign accept_s      = bus.req_valid && ready_s;
    assign bus.req_ready = ready_s;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_rdata = rsp_rdata_r;
    assign busy          = busy_r;

    // S1 lane decode, same-address resolution and writeback values
    always_comb begin
        logic [EW-1:0] sum_v;
        logic          same_v;
        lane_en_s  = '0;
        lane_win_s = '0;
        lane_wr_s  = '0;
        rd_data_s  = '0;
        sum_v      = '0;
        same_v     = 1'b0;
`ifdef ACC_SAT_EN
        lane_clip_s = '0;
`endif
        for (int i = 0; i < LANES; i++) begin
            lane_addr_s[i] = s1_addr_r[i*AW +: AW];
            lane_en_s[i]   = s1_valid_r && s1_en_r[i] && in_range(lane_addr_s[i]);
            lane_old_s[i]  = lane_en_s[i] ? mem_r[lane_addr_s[i]] : {DW{1'b0}};
            rd_data_s[i*DW +: DW] = lane_old_s[i];
        end
        // The highest-index lane of each address is its single writer; ACC sums all its lanes.
        for (int i = 0; i < LANES; i++) begin
            lane_win_s[i] = lane_en_s[i];
            sum_v = sext(lane_old_s[i]);
            for (int j = 0; j < LANES; j++) begin
                same_v = lane_en_s[j] && (lane_addr_s[j] == lane_addr_s[i]);
                sum_v  = sum_v + (same_v ? sext(s1_wdata_r[j*DW +: DW]) : {EW{1'b0}});
                lane_win_s[i] = lane_win_s[i] && !(same_v && (j > i));
            end
            lane_wr_s[i] = lane_win_s[i] && ((s1_op_r == OP_WRITE) || (s1_op_r == OP_ACC));
            if (s1_op_r == OP_ACC) begin
`ifdef ACC_SAT_EN
                lane_wval_s[i] = sat_val(sum_v);
                lane_clip_s[i] = lane_win_s[i] && clips(sum_v);
`else
                lane_wval_s[i] = sum_v;
`endif
            end else begin
                lane_wval_s[i] = s1_wdata_r[i*DW +: DW];
            end
        end
    end

    // Clear group addressing; the final partial group is masked at DEPTH
    always_comb begin
        logic [AW1-1:0] clr_sum_v;
        clr_hit_s  = '0;
        clr_sum_v  = '0;
        clr_last_s = (32'(clr_base_r) + 32'(LANES)) >= 32'(DEPTH);
        for (int k = 0; k < LANES; k++) begin
            clr_sum_v    = {1'b0, clr_base_r} + AW1'(k);
            clr_hit_s[k] = 32'(clr_sum_v) < 32'(DEPTH);
            clr_idx_s[k] = clr_sum_v[AW-1:0];
        end
    end

    // Clear sequencer FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            clr_base_r <= '0;
            busy_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (clr_start) begin
                        state_r    <= ST_CLEAR;
                        clr_base_r <= '0;
                        busy_r     <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    if (clr_last_s) begin
                        state_r    <= ST_IDLE;
                        clr_base_r <= '0;
                        busy_r     <= 1'b0;
                    end else begin
                        clr_base_r <= clr_base_r + AW'(LANES);
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    clr_base_r <= '0;
                    busy_r     <= 1'b0;
                end
            endcase
        end
    end

    // S1 capture and READ response register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r  <= 1'b0;
            s1_op_r     <= 2'b11;
            s1_en_r     <= '0;
            s1_addr_r   <= '0;
            s1_wdata_r  <= '0;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= '0;
        end else begin
            s1_valid_r <= accept_s;
            if (accept_s) begin
                s1_op_r    <= bus.req_op;
                s1_en_r    <= bus.req_lane_en;
                s1_addr_r  <= bus.req_addr;
                s1_wdata_r <= bus.req_wdata;
            end
            rsp_valid_r <= s1_valid_r && (s1_op_r == OP_READ);
            if (s1_valid_r && (s1_op_r == OP_READ)) begin
                rsp_rdata_r <= rd_data_s;
            end
        end
    end

`ifdef ACC_SAT_EN
    // Saturation pulse at the ACC writeback edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_sat_r <= 1'b0;
        end else begin
            acc_sat_r <= s1_valid_r && (s1_op_r == OP_ACC) && (|lane_clip_s);
        end
    end
    assign acc_sat = acc_sat_r;
`else
    assign acc_sat = 1'b0;
`endif

    // Array writes; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (state_r == ST_CLEAR) begin
            for (int k = 0; k < LANES; k++) begin
                if (clr_hit_s[k]) begin
                    mem_r[clr_idx_s[k]] <= '0;
                end
            end
        end else begin
            for (int i = 0; i < LANES; i++) begin
                if (lane_wr_s[i]) begin
                    mem_r[lane_addr_s[i]] <= lane_wval_s[i];
                end
            end
        end
    end
endmodule

// File: tb/tb_vec_accum_mem.sv
// Randomized self-checking bench for vec_accum_mem against an array-based reference model.
module tb_vec_accum_mem;
    localparam int LANES = 4;
    localparam int DW    = 32;
    localparam int DEPTH = 1001;
    localparam int AW    = $clog2(DEPTH);
    localparam int NGRP  = (DEPTH + LANES - 1) / LANES;
    localparam int BW    = LANES * DW;
    localparam longint MAXV = (longint'(1) <<< (DW - 1)) - 1;
    localparam longint MINV = -(longint'(1) <<< (DW - 1));

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clr_start = 1'b0;
    logic busy;
    logic acc_sat;

    vec_accum_mem_if #(.LANES(LANES), .DW(DW), .AW(AW)) bus ();

    vec_accum_mem #(.LANES(LANES), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .clr_start (clr_start),
        .busy      (busy),
        .acc_sat   (acc_sat)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] mdl_mem [DEPTH];
    logic          pend_valid = 1'b0;
    logic [BW-1:0] pend_rdata = '0;
    logic          pend_sat = 1'b0;

    task automatic check_eq(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [LANES*AW-1:0] pa(input int a0, input int a1, input int a2, input int a3);
        return {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
    endfunction

    function automatic logic [BW-1:0] pd(input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                                         input logic [DW-1:0] d2, input logic [DW-1:0] d3);
        return {d3, d2, d1, d0};
    endfunction

    // Reference: sequential per-lane semantics, ACC totals kept at full precision per address.
    task automatic model_apply(input logic [1:0] op, input logic [LANES-1:0] en,
                               input logic [LANES*AW-1:0] addr, input logic [BW-1:0] wdata);
        longint tot [int];
        int a;
        pend_rdata = '0;
        pend_sat   = 1'b0;
        pend_valid = (op == 2'b00);
        for (int i = 0; i < LANES; i++) begin
            a = int'(addr[i*AW +: AW]);
            if (en[i] && a < DEPTH) begin
                case (op)
                    2'b00: pend_rdata[i*DW +: DW] = mdl_mem[a];
                    2'b01: mdl_mem[a] = wdata[i*DW +: DW];
                    2'b10: begin
                        if (!tot.exists(a)) tot[a] = longint'($signed(mdl_mem[a]));
                        tot[a] += longint'($signed(wdata[i*DW +: DW]));
                    end
                    default: ;
                endcase
            end
        end
        foreach (tot[k]) begin
`ifdef ACC_SAT_EN
            if (tot[k] > MAXV) begin tot[k] = MAXV; pend_sat = 1'b1; end
            if (tot[k] < MINV) begin tot[k] = MINV; pend_sat = 1'b1; end
`endif
            mdl_mem[k] = tot[k][DW-1:0];
        end
    endtask

    task automatic check_rsp();
        check_eq("rsp_valid", bus.rsp_valid, pend_valid);
        if (pend_valid) check_eq("rsp_rdata", bus.rsp_rdata, pend_rdata);
        check_eq("acc_sat", acc_sat, pend_sat);
    endtask

    task automatic issue(input logic [1:0] op, input logic [LANES-1:0] en,
                         input logic [LANES*AW-1:0] addr, input logic [BW-1:0] wdata);
        bus.req_valid   = 1'b1;
        bus.req_op      = op;
        bus.req_lane_en = en;
        bus.req_addr    = addr;
        bus.req_wdata   = wdata;
        check_eq("req_ready", bus.req_ready, 1'b1);
        @(posedge clk); #1;
        check_rsp();
        model_apply(op, en, addr, wdata);
        bus.req_valid = 1'b0;
    endtask

    task automatic idle_cycle();
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        check_rsp();
        pend_valid = 1'b0;
        pend_sat   = 1'b0;
    endtask

    // abort_after > 0 pulls rst_n low after that many busy cycles have been seen.
    task automatic run_clear(input int abort_after, output int busy_cycles);
        busy_cycles     = 0;
        clr_start       = 1'b1;
        bus.req_valid   = 1'b1;
        bus.req_op      = 2'b00;
        bus.req_lane_en = '1;
        bus.req_addr    = '0;
        #1;
        check_eq("ready_blocked", bus.req_ready, 1'b0);
        @(posedge clk); #1;
        check_rsp();
        clr_start = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (!busy) break;
            busy_cycles++;
            check_eq("rsp_during_clr", bus.rsp_valid, 1'b0);
            check_eq("ready_during_clr", bus.req_ready, 1'b0);
            clr_start = (c == 40);
            if (abort_after > 0 && busy_cycles == abort_after) begin
                rst_n = 1'b0;
                #1;
                check_eq("busy_abort", busy, 1'b0);
                break;
            end
            @(posedge clk); #1;
        end
        clr_start     = 1'b0;
        bus.req_valid = 1'b0;
        if (!rst_n) begin
            @(posedge clk); #1;
            rst_n = 1'b1;
        end
    endtask

    function automatic int rand_addr();
        int r = $urandom_range(0, 9);
        if (r < 5) return $urandom_range(0, 7);
        if (r < 7) return $urandom_range(DEPTH - 4, (1 << AW) - 1);
        return $urandom_range(0, (1 << AW) - 1);
    endfunction

    function automatic logic [DW-1:0] rand_data();
        int r = $urandom_range(0, 7);
        if (r == 0) return 32'h7FFF_FFFF;
        if (r == 1) return 32'h8000_0000;
        if (r == 2) return 32'hFFFF_FFFF;
        return DW'($urandom);
    endfunction

    initial begin
        int n;
        bus.req_valid   = 1'b0;
        bus.req_op      = 2'b11;
        bus.req_lane_en = '0;
        bus.req_addr    = '0;
        bus.req_wdata   = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_acc_sat", acc_sat, 1'b0);
        check_eq("rst_rsp_valid", bus.rsp_valid, 1'b0);
        check_eq("rst_rsp_rdata", bus.rsp_rdata, '0);
        check_eq("rst_ready", bus.req_ready, 1'b1);
        rst_n = 1'b1;
        idle_cycle();

        // Full clear, including an ignored clr_start pulse mid-sequence
        run_clear(0, n);
        check_eq("clr_cycles", BW'(n), BW'(NGRP));
        for (int a = 0; a < DEPTH; a++) mdl_mem[a] = '0;
        idle_cycle();

        issue(2'b00, 4'hF, pa(0, 1, DEPTH - 2, DEPTH - 1), '0);
        idle_cycle();

        // Write then read with no bubble
        issue(2'b01, 4'hF, pa(5, 6, 7, 8), pd(32'hA, 32'hB, 32'hC, 32'hD));
        issue(2'b00, 4'hF, pa(5, 6, 7, 8), '0);
        // Same-address WRITE then ACC
        issue(2'b01, 4'hF, pa(9, 9, 9, 9), pd(32'd1, 32'd2, 32'd3, 32'd4));
        issue(2'b00, 4'hF, pa(9, 9, 9, 9), '0);
        issue(2'b10, 4'hF, pa(9, 9, 9, 9), pd(32'd1, 32'd1, 32'd1, 32'd1));
        issue(2'b00, 4'h1, pa(9, 9, 9, 9), '0);
        // Positive overflow on ACC
        issue(2'b01, 4'h1, pa(3, 0, 0, 0), pd(32'h7FFF_FFFF, 32'h0, 32'h0, 32'h0));
        issue(2'b10, 4'h1, pa(3, 0, 0, 0), pd(32'h1, 32'h0, 32'h0, 32'h0));
        issue(2'b00, 4'h1, pa(3, 0, 0, 0), '0);
        // Disabled lanes and an out-of-range lane
        issue(2'b01, 4'b0101, pa(20, 21, DEPTH, 23), pd(32'h11, 32'h22, 32'h33, 32'h44));
        issue(2'b00, 4'hF, pa(20, 21, DEPTH, 23), '0);
        issue(2'b00, 4'b1010, pa(20, 20, 20, 20), '0);
        idle_cycle();

        for (int it = 0; it < 400; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                idle_cycle();
            end else begin
                issue(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                      pa(rand_addr(), rand_addr(), rand_addr(), rand_addr()),
                      pd(rand_data(), rand_data(), rand_data(), rand_data()));
            end
        end
        idle_cycle();

        // Reset mid-clear: words past the clear pointer must survive
        issue(2'b01, 4'hF, pa(0, 50, 115, 116), pd(32'h5A5A_0001, 32'h5A5A_0002, 32'h5A5A_0003, 32'h5A5A_0004));
        issue(2'b01, 4'hF, pa(150, 400, DEPTH - 1, 600), pd(32'hC0DE_0001, 32'hC0DE_0002, 32'hC0DE_0003, 32'hC0DE_0004));
        idle_cycle();
        run_clear(30, n);
        check_eq("abort_cycles", BW'(n), BW'(30));
        for (int a = 0; a < (n - 1) * LANES && a < DEPTH; a++) mdl_mem[a] = '0;
        pend_valid = 1'b0;
        pend_sat   = 1'b0;
        idle_cycle();

        for (int g = 0; g < (1 << AW) / LANES; g++) begin
            issue(2'b00, 4'hF, pa(g * 4, g * 4 + 1, g * 4 + 2, g * 4 + 3), '0);
        end
        idle_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
